// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding,
// counter sizing and the quotient pattern reported on a divide by zero.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } div_state_t;

    // Bits needed to hold a step counter that starts at width and counts to 1.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Divide by zero returns an all-ones quotient; replicate this bit to WIDTH.
    localparam logic DBZ_QUOTIENT_BIT = 1'b1;

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle between the multiply/divide unit and the divider.
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = 32
);

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits. The shifted value keeps an
// extra top bit so divisors with their MSB set compare correctly.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dvs_mag,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    assign shifted = {rem_in, dvd_bit};

    // Trial subtraction; the true difference is below the divisor, so the
    // low WIDTH bits of the subtraction are exact.
    always_comb begin
        rem_out = shifted[WIDTH-1:0];
        q_bit   = 1'b0;
        if (shifted >= {1'b0, dvs_mag}) begin
            rem_out = shifted[WIDTH-1:0] - dvs_mag;
            q_bit   = 1'b1;
        end else begin
            rem_out = shifted[WIDTH-1:0];
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (DIV/DIVU). Operands are converted to
// magnitudes on acceptance, WIDTH restoring steps run one per clock, and the
// sign fix-up is applied on the single FINISH edge that also pulses done.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    seq_divider_if.slave  bus
);

    localparam int               CW         = count_width(WIDTH);
    localparam logic [CW-1:0]    COUNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]    COUNT_LAST = CW'(1);
    localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{DBZ_QUOTIENT_BIT}};
    localparam logic [WIDTH-1:0] MIN_VAL    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ZERO       = {WIDTH{1'b0}};

    div_state_t       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] dvd_raw;
    logic             neg_q;
    logic             neg_r;
    logic             dbz_pend;
    logic             ovf_pend;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic             ovf_case;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    // Dividend bits are consumed MSB first by shifting dvd_mag left each step.
    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem),
        .dvd_bit (dvd_mag[WIDTH-1]),
        .dvs_mag (dvs_mag),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Operand magnitudes and overflow detection from the live request inputs.
    always_comb begin
        dvd_neg  = bus.is_signed & bus.dividend[WIDTH-1];
        dvs_neg  = bus.is_signed & bus.divisor[WIDTH-1];
        dvd_abs  = bus.dividend;
        dvs_abs  = bus.divisor;
        if (dvd_neg) begin
            dvd_abs = -bus.dividend;
        end else begin
            dvd_abs = bus.dividend;
        end
        if (dvs_neg) begin
            dvs_abs = -bus.divisor;
        end else begin
            dvs_abs = bus.divisor;
        end
        ovf_case = bus.is_signed & (bus.dividend == MIN_VAL) & (bus.divisor == ALL_ONES);
    end

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            count           <= {CW{1'b0}};
            rem             <= ZERO;
            quo             <= ZERO;
            dvd_mag         <= ZERO;
            dvs_mag         <= ZERO;
            dvd_raw         <= ZERO;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            dbz_pend        <= 1'b0;
            ovf_pend        <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= ZERO;
            bus.remainder   <= ZERO;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvd_mag         <= dvd_abs;
                        dvs_mag         <= dvs_abs;
                        dvd_raw         <= bus.dividend;
                        neg_q           <= dvd_neg ^ dvs_neg;
                        neg_r           <= dvd_neg;
                        ovf_pend        <= ovf_case;
                        rem             <= ZERO;
                        quo             <= ZERO;
                        count           <= COUNT_INIT;
                        bus.div_by_zero <= 1'b0;
                        bus.overflow    <= 1'b0;
                        bus.busy        <= 1'b1;
                        if (bus.divisor == ZERO) begin
                            dbz_pend <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            dbz_pend <= 1'b0;
                            state    <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    rem     <= step_rem;
                    quo     <= {quo[WIDTH-2:0], step_q};
                    dvd_mag <= {dvd_mag[WIDTH-2:0], 1'b0};
                    count   <= count - COUNT_LAST;
                    if (count == COUNT_LAST) begin
                        state <= FINISH;
                    end else begin
                        state <= CALC;
                    end
                end
                FINISH: begin
                    if (dbz_pend) begin
                        bus.quotient    <= ALL_ONES;
                        bus.remainder   <= dvd_raw;
                        bus.div_by_zero <= 1'b1;
                        bus.overflow    <= 1'b0;
                    end else begin
                        // MIN / -1 wraps naturally: magnitude 2^(W-1), no negation.
                        bus.quotient    <= neg_q ? -quo : quo;
                        bus.remainder   <= neg_r ? -rem : rem;
                        bus.div_by_zero <= 1'b0;
                        bus.overflow    <= ovf_pend;
                    end
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider at WIDTH=32 and WIDTH=8.
module tb_seq_divider;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;

    seq_divider_if #(.WIDTH(32)) bus32 ();
    seq_divider_if #(.WIDTH(8))  bus8 ();

    seq_divider #(.WIDTH(32)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Truncating reference built on the simulator's own / and % operators.
    function automatic void ref_model(input int w, input bit sgn, input logic [63:0] a,
                                      input logic [63:0] b, output logic [63:0] q,
                                      output logic [63:0] r, output bit dbz, output bit ovf);
        logic [63:0] mask;
        longint      sa;
        longint      sb;
        mask = (64'h1 << w) - 64'h1;
        dbz  = 1'b0;
        ovf  = 1'b0;
        if (b == 64'h0) begin
            dbz = 1'b1;
            q   = mask;
            r   = a;
        end else if (sgn) begin
            sa  = $signed(a << (64 - w)) >>> (64 - w);
            sb  = $signed(b << (64 - w)) >>> (64 - w);
            q   = 64'(sa / sb) & mask;
            r   = 64'(sa % sb) & mask;
            ovf = (a == (64'h1 << (w - 1))) && (b == mask);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic drive(input int w, input bit st, input bit sgn, input logic [63:0] a, input logic [63:0] b);
        if (w == 32) begin
            bus32.start     = st;
            bus32.is_signed = sgn;
            bus32.dividend  = a[31:0];
            bus32.divisor   = b[31:0];
        end else begin
            bus8.start     = st;
            bus8.is_signed = sgn;
            bus8.dividend  = a[7:0];
            bus8.divisor   = b[7:0];
        end
    endtask

    task automatic do_op(input int w, input string tag, input bit sgn,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_q, input logic [63:0] exp_r,
                         input bit exp_dbz, input bit exp_ovf, input bit disturb);
        int lat;
        bit got;
        logic [63:0] oq;
        logic [63:0] orm;
        bit obz;
        bit oov;
        @(negedge clk);
        check_value({tag, "_idle"}, (w == 32) ? 64'(bus32.busy) : 64'(bus8.busy), 64'h0);
        drive(w, 1'b1, sgn, a, b);
        @(posedge clk);
        #1;
        drive(w, 1'b0, ~sgn, ~a, a ^ b);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            if (disturb && lat == 4) begin
                drive(w, 1'b1, 1'b0, 64'd9, 64'd3);
            end
            @(posedge clk);
            #1;
            lat++;
            bus32.start = 1'b0;
            bus8.start  = 1'b0;
            got = (w == 32) ? bus32.done : bus8.done;
        end
        if (w == 32) begin
            oq = 64'(bus32.quotient); orm = 64'(bus32.remainder);
            obz = bus32.div_by_zero;  oov = bus32.overflow;
        end else begin
            oq = 64'(bus8.quotient);  orm = 64'(bus8.remainder);
            obz = bus8.div_by_zero;   oov = bus8.overflow;
        end
        check_value({tag, "_lat"}, 64'(lat), exp_dbz ? 64'd1 : 64'(w + 1));
        check_value({tag, "_q"}, oq, exp_q);
        check_value({tag, "_r"}, orm, exp_r);
        check_value({tag, "_dbz"}, 64'(obz), 64'(exp_dbz));
        check_value({tag, "_ovf"}, 64'(oov), 64'(exp_ovf));
    endtask

    task automatic rand_op(input int w, input int idx);
        logic [63:0] mask;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [63:0] r;
        bit sgn;
        bit dbz;
        bit ovf;
        mask = (64'h1 << w) - 64'h1;
        sgn  = 1'($urandom_range(0, 1));
        a    = {32'($urandom()), 32'($urandom())} & mask;
        if ($urandom_range(0, 2) == 0) begin
            b = 64'($urandom_range(0, 17));
        end else begin
            b = {32'($urandom()), 32'($urandom())} & mask;
        end
        if ($urandom_range(0, 1) == 1) begin
            b = b >> $urandom_range(0, w - 1);
        end
        ref_model(w, sgn, a, b, q, r, dbz, ovf);
        do_op(w, $sformatf("rnd%0d_%0d", w, idx), sgn, a, b, q, r, dbz, ovf, 1'b0);
    endtask

    initial begin
        bit saw_done;
        n_vec  = 0;
        n_miss = 0;
        reset  = 1'b1;
        drive(32, 1'b0, 1'b0, 64'h0, 64'h0);
        drive(8, 1'b0, 1'b0, 64'h0, 64'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_value("rst_busy", 64'(bus32.busy), 64'h0);
        check_value("rst_done", 64'(bus32.done), 64'h0);
        check_value("rst_q", 64'(bus32.quotient), 64'h0);
        check_value("rst_r", 64'(bus32.remainder), 64'h0);
        check_value("rst_flags", 64'({bus32.div_by_zero, bus32.overflow}), 64'h0);

        // Signed sign rules.
        do_op(32, "s7_2", 1'b1, 64'd7, 64'd2, 64'd3, 64'd1, 1'b0, 1'b0, 1'b0);
        do_op(32, "sm7_2", 1'b1, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 64'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        do_op(32, "s7_m2", 1'b1, 64'd7, 64'hFFFFFFFE, 64'hFFFFFFFD, 64'd1, 1'b0, 1'b0, 1'b0);
        // Unsigned with large operands, then the same bits as signed.
        do_op(32, "u_fffe_2", 1'b0, 64'hFFFFFFFE, 64'd2, 64'h7FFFFFFF, 64'd0, 1'b0, 1'b0, 1'b0);
        do_op(32, "u_big_div", 1'b0, 64'hFFFFFFFF, 64'h80000000, 64'd1, 64'h7FFFFFFF, 1'b0, 1'b0, 1'b0);
        do_op(32, "s_big_div", 1'b1, 64'hFFFFFFFF, 64'h80000000, 64'd0, 64'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        // Divide by zero, then a valid op clears the flag.
        do_op(32, "dbz", 1'b1, 64'd5, 64'd0, 64'hFFFFFFFF, 64'd5, 1'b1, 1'b0, 1'b0);
        do_op(32, "after_dbz", 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0, 1'b0);
        // Signed overflow.
        do_op(32, "ovf", 1'b1, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 64'd0, 1'b0, 1'b1, 1'b0);
        // start while busy must be ignored.
        do_op(32, "busy_start", 1'b0, 64'd1000, 64'd10, 64'd100, 64'd0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of CALC.
        @(negedge clk);
        drive(32, 1'b1, 1'b0, 64'd1000, 64'd10);
        @(posedge clk);
        #1;
        bus32.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_value("midrst_busy", 64'(bus32.busy), 64'h0);
        check_value("midrst_q", 64'(bus32.quotient), 64'h0);
        check_value("midrst_r", 64'(bus32.remainder), 64'h0);
        check_value("midrst_flags", 64'({bus32.done, bus32.div_by_zero, bus32.overflow}), 64'h0);
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            saw_done = saw_done | bus32.done;
        end
        check_value("midrst_no_done", 64'(saw_done), 64'h0);
        do_op(32, "post_rst", 1'b1, 64'hFFFFFF9C, 64'd7, 64'hFFFFFFF2, 64'hFFFFFFFE, 1'b0, 1'b0, 1'b0);

        // Back-to-back: each do_op raises start in the previous op's done cycle.
        do_op(32, "b2b_a", 1'b0, 64'd50, 64'd5, 64'd10, 64'd0, 1'b0, 1'b0, 1'b0);
        do_op(32, "b2b_b", 1'b1, 64'hFFFFFFCE, 64'd5, 64'hFFFFFFF6, 64'd0, 1'b0, 1'b0, 1'b0);

        // Narrow instance boundaries.
        do_op(8, "w8_ovf", 1'b1, 64'h80, 64'hFF, 64'h80, 64'h00, 1'b0, 1'b1, 1'b0);
        do_op(8, "w8_ubig", 1'b0, 64'hFF, 64'h80, 64'h01, 64'h7F, 1'b0, 1'b0, 1'b0);
        do_op(8, "w8_sm7_2", 1'b1, 64'hF9, 64'h02, 64'hFD, 64'hFF, 1'b0, 1'b0, 1'b0);
        do_op(8, "w8_dbz", 1'b0, 64'h2A, 64'h00, 64'hFF, 64'h2A, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            rand_op(8, i);
        end
        for (int i = 0; i < 30; i++) begin
            rand_op(32, i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Parametrised multi-cycle restoring divider for the processor's multiply/divide unit. Supports signed (DIV) and unsigned (DIVU) operation. Provides a start/busy/done handshake and explicit divide-by-zero and signed-overflow flags. Quotient feeds Lo and remainder feeds Hi in the register file path.

Parameters:
WIDTH, 32, operand/result width in bits (>= 4)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  request; accepted only when busy=0
is_signed  in  1  1 = two's-complement divide, 0 = unsigned; sampled with start
dividend  in  WIDTH  sampled with start
divisor  in  WIDTH  sampled with start
busy  out  1  operation in progress
done  out  1  single-cycle pulse when results are valid
quotient  out  WIDTH  result (Lo)
remainder  out  WIDTH  result (Hi)
div_by_zero  out  1  last op had divisor=0
overflow  out  1  last op was signed MIN / -1

Behaviour:
- reset (synchronous, active-high; clk) forces:
  - state IDLE; busy=0, done=0;
  - quotient=0, remainder=0, div_by_zero=0, overflow=0;
  - internal counters and registers cleared.
- reset mid-operation aborts the divide; no done pulse is produced.
- FSM states: IDLE, CALC, FINISH.
- IDLE:
  - If start=1 at edge E0, latch operands, is_signed, and sign bits.
  - Form magnitudes: absolute value if is_signed and MSB=1, else raw.
  - Clear the partial remainder; set count=WIDTH; clear div_by_zero and overflow; busy=1.
  - If divisor=0, go to FINISH; otherwise go to CALC.
- CALC: one restoring step per clock.
  - rem = {rem[WIDTH-2:0], dvd_mag[count-1]}.
  - If rem >= dvs_mag, subtract and set q[count-1]=1.
  - Decrement count; after WIDTH steps (edge E_WIDTH), go to FINISH.
  - The partial remainder is WIDTH+1 bits internally, so unsigned divisors >= 2^(WIDTH-1) are handled correctly.
- FINISH: a single edge writes the outputs, pulses done=1 for exactly one cycle, sets busy=0, and returns to IDLE.
- Sign rules (truncation toward zero):
  - quotient negated iff is_signed and sign(dividend) != sign(divisor);
  - remainder takes the sign of the dividend (negated iff is_signed and dividend MSB=1);
  - so |remainder| < |divisor| and dividend = quotient*divisor + remainder.
- Divide by zero:
  - div_by_zero=1, quotient = all ones, remainder = dividend;
  - done at edge E1, i.e. 1 cycle after E0.
- Signed overflow (dividend=100..0, divisor=all ones, is_signed=1):
  - overflow=1, quotient=100..0 (natural wrap), remainder=0;
  - full latency; no special-case path needed.
- Latency: normal ops raise done WIDTH+1 edges after the accepting edge E0 (33 for WIDTH=32).
- Result lifetime: outputs and flags hold their values after done until the next accepted start; they are not cleared at start.
- start while busy=1 is ignored (no queueing; operands not resampled).
- Back-to-back: start may be asserted in the done cycle; it is accepted because busy=0 there.
- Operand inputs may change freely after the accepting edge.

Decomposition:
- Shared package div_pkg holds:
  - the state enum (IDLE, CALC, FINISH);
  - the counter-width function clog2(WIDTH+1);
  - the div-by-zero quotient constant (all ones).
- Sub-module div_step: combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new remainder, quotient bit.
  - Instantiated once in seq_divider. Sign handling and the FSM stay in seq_divider.

Test Plan:
1. WIDTH=32, signed, 7 / 2 → quotient=3, remainder=1, done exactly 33 cycles after the start edge. Then -7 / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Then 7 / -2 → quotient=0xFFFFFFFD, remainder=1.
2. Unsigned 0xFFFFFFFE / 2 → 0x7FFFFFFF r 0. Then unsigned 0xFFFFFFFF / 0x80000000 → quotient=1, remainder=0x7FFFFFFF. Then the same operands signed → quotient=0, remainder=0xFFFFFFFF.
3. 5 / 0 → div_by_zero=1, quotient=0xFFFFFFFF, remainder=5, done 1 cycle after start. Next valid op clears div_by_zero.
4. Signed 0x80000000 / 0xFFFFFFFF → overflow=1, quotient=0x80000000, remainder=0.
5. start pulsed while busy with different operands → ignored, first result unchanged. reset asserted mid-CALC → busy=0, outputs 0, no done pulse. A new start then completes normally.
6. start asserted in the done cycle (back-to-back) → second op accepted, done again 33 cycles later. Random signed/unsigned regression vs reference model with WIDTH=8 and WIDTH=32.
